// File: rtl/fpu_mul_pkg.sv
// ============================================================================
// Module   : fpu_mul_pkg
// Brief    : Shared types and width defaults for the FPU mantissa multiplier.
// Revision : 1.0
// ============================================================================
`default_nettype none

package fpu_mul_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } mul_state_t;

    localparam int MANT_W   = 24;
    localparam int STICKY_W = 22;

endpackage

`default_nettype wire

// File: rtl/iter_mantissa_multiplier.sv
// ============================================================================
// Module   : iter_mantissa_multiplier
// Brief    : Shift-add unsigned mantissa multiplier, one multiplier bit per
//            clock, valid/ready on both sides. MULT_STICKY_EN adds `sticky`.
// Revision : 1.0
// ============================================================================
`default_nettype none

module iter_mantissa_multiplier
    import fpu_mul_pkg::*;
#(
    parameter int MCAND_LENGTH  = MANT_W,
    parameter int MPLIER_LENGTH = MANT_W
`ifdef MULT_STICKY_EN
    ,
    parameter int STICKY_BITS   = STICKY_W
`endif
) (
    input  logic                                  clk,
    input  logic                                  rst_n,
    input  logic                                  in_valid,
    output logic                                  in_ready,
    input  logic [MCAND_LENGTH-1:0]               multiplicand,
    input  logic [MPLIER_LENGTH-1:0]              multiplier,
    output logic                                  out_valid,
    input  logic                                  out_ready,
    output logic [MCAND_LENGTH+MPLIER_LENGTH-1:0] product,
    output logic                                  busy
`ifdef MULT_STICKY_EN
    ,
    output logic                                  sticky
`endif
);

    localparam int PRODUCT_LENGTH = MCAND_LENGTH + MPLIER_LENGTH;
    localparam int CNT_W          = (MPLIER_LENGTH > 1) ? $clog2(MPLIER_LENGTH) : 1;

    mul_state_t               state_q, state_d;
    logic [MCAND_LENGTH:0]    a_q, a_d;
    logic [MPLIER_LENGTH-1:0] q_q, q_d;
    logic [MCAND_LENGTH-1:0]  m_q, m_d;
    logic [CNT_W-1:0]         cnt_q, cnt_d;

    logic [MCAND_LENGTH:0]                a_sum;
    logic [MCAND_LENGTH+MPLIER_LENGTH:0]  aq_shift;

    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        q_d      = q_q;
        m_d      = m_q;
        cnt_d    = cnt_q;
        a_sum    = '0;
        aq_shift = '0;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    m_d     = multiplicand;
                    a_d     = '0;
                    q_d     = multiplier;
                    cnt_d   = CNT_W'(MPLIER_LENGTH - 1);
                    state_d = CALC;
                end
            end
            CALC: begin
                // A carries one spare bit so the conditional add never loses its carry
                a_sum    = q_q[0] ? (a_q + {1'b0, m_q}) : a_q;
                aq_shift = {a_sum, q_q} >> 1;
                a_d      = aq_shift[MCAND_LENGTH+MPLIER_LENGTH:MPLIER_LENGTH];
                q_d      = aq_shift[MPLIER_LENGTH-1:0];
                if (cnt_q == '0) begin
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            a_q     <= '0;
            q_q     <= '0;
            m_q     <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            q_q     <= q_d;
            m_q     <= m_d;
            cnt_q   <= cnt_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign busy      = (state_q != IDLE);
    // Mask the accumulator outside DONE so no partial product is ever visible
    assign product   = out_valid ? {a_q[MCAND_LENGTH-1:0], q_q} : '0;

`ifdef MULT_STICKY_EN
    logic [PRODUCT_LENGTH-1:0] prod_d;
    logic                      sticky_q, sticky_d;

    always_comb begin
        prod_d   = {a_d[MCAND_LENGTH-1:0], q_d};
        sticky_d = (state_d == DONE) && (|prod_d[STICKY_BITS-1:0]);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sticky_q <= 1'b0;
        end else begin
            sticky_q <= sticky_d;
        end
    end

    assign sticky = sticky_q;
`endif

endmodule

`default_nettype wire
